// File: rtl/mealy_seq_detector.sv
// Serial Mealy detector for a programmable bit pattern, with overlapping matches.
// The next-state table is derived from PATTERN at elaboration using the KMP failure rule.
module mealy_seq_detector #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1
) (
  input  logic             clock,
  input  logic             ares,
  input  logic             a,
  output logic             w,
  output logic             w_q,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt
);

  // Three bits cover the largest legal pattern (8 bits -> S0..S7), so every
  // encoding is a named state; the port exposes only the SW bits in use.
  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  // Indexed by {k, a}; entries for k >= PAT_LEN are unreachable and fall back to S0.
  typedef logic [15:0][2:0] tbl_t;

  function automatic tbl_t build_tbl();
    tbl_t t;
    int   nk;
    int   idx;
    logic ok;
    logic sb;
    t = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        // s = first k pattern bits followed by b; keep the longest proper
        // pattern prefix that is also a suffix of s.
        nk = 0;
        for (int l = 1; l < PAT_LEN; l++) begin
          if (l <= k + 1) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
              idx = k + 1 - l + j;
              sb  = (idx == k) ? ((b == 1) ? 1'b1 : 1'b0) : PATTERN[PAT_LEN-1-idx];
              if (sb != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
            end
            if (ok) nk = l;
          end
        end
        t[k*2+b] = 3'(nk);
      end
    end
    return t;
  endfunction

  localparam tbl_t   NEXT_TBL = build_tbl();
  localparam state_t S_LAST   = state_t'(3'(PAT_LEN - 1));

  state_t state_q;
  state_t next_state;

  always_ff @(posedge clock or posedge ares) begin
    if (ares) begin
      state_q <= S0;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_t'(NEXT_TBL[{state_q, a}]);
    w          = 1'b0;
    if (!ares && (state_q == S_LAST) && (a == PATTERN[0])) begin
      w = 1'b1;
    end
  end

  // Registered flag copy and saturating match counter.
  always_ff @(posedge clock or posedge ares) begin
    if (ares) begin
      w_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      w_q <= w;
      if (w && (match_cnt != {CNT_W{1'b1}})) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

  assign state = state_q[SW-1:0];

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: directed scenarios followed by a random stream,
// checked against a history-based reference model (last bits vs. pattern).
module tb_mealy_seq_detector;

  localparam int                 PAT_LEN = 3;
  localparam logic [PAT_LEN-1:0] PATTERN = 3'b101;
  localparam int                 SW      = 2;
  localparam int                 CNT_W   = 8;
  localparam int                 SAT_MAX = 3;

  logic             clock;
  logic             ares;
  logic             a;
  logic             w;
  logic             w_q;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_cnt;
  logic             w_s;
  logic             w_q_s;
  logic [SW-1:0]    state_s;
  logic [1:0]       match_cnt_s;

  int vectors;
  int miscompares;

  // reference model state
  bit hist[$];
  int exp_cnt;
  int exp_sat;
  bit exp_wq;

  mealy_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .ares(ares), .a(a),
    .w(w), .w_q(w_q), .state(state), .match_cnt(match_cnt)
  );

  mealy_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)) u_sat (
    .clock(clock), .ares(ares), .a(a),
    .w(w_s), .w_q(w_q_s), .state(state_s), .match_cnt(match_cnt_s)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  // Full match: the received bits followed by nb end with the whole pattern.
  function automatic bit model_w(input bit nb);
    int n;
    if (ares) return 1'b0;
    n = hist.size();
    if (n + 1 < PAT_LEN) return 1'b0;
    if (nb != PATTERN[0]) return 1'b0;
    for (int i = 1; i < PAT_LEN; i++) begin
      if (hist[n-i] != PATTERN[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Longest proper pattern prefix that ends the received stream.
  function automatic int model_state();
    int n;
    bit ok;
    n = hist.size();
    for (int l = PAT_LEN - 1; l >= 1; l--) begin
      if (l <= n) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (hist[n-l+j] != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
        end
        if (ok) return l;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_cnt = 0;
    exp_sat = 0;
    exp_wq  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, ".w"},     32'(w),     32'(model_w(a)));
    chk({tag, ".w_s"},   32'(w_s),   32'(model_w(a)));
    chk({tag, ".state"}, 32'(state), 32'(ares ? 0 : model_state()));
  endtask

  task automatic chk_all(input string tag);
    chk_comb(tag);
    chk({tag, ".w_q"},   32'(w_q),         32'(exp_wq));
    chk({tag, ".cnt"},   32'(match_cnt),   32'(exp_cnt));
    chk({tag, ".sat"},   32'(match_cnt_s), 32'(exp_sat));
  endtask

  // ---------------- drivers ----------------
  // One rising edge with the current a/ares, then model update and full check.
  task automatic tick(input string tag);
    bit ew;
    ew = model_w(a);
    @(posedge clock);
    if (ares) begin
      model_reset();
    end else begin
      exp_wq = ew;
      if (ew) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_sat < SAT_MAX) exp_sat++;
      end
      hist.push_back(a);
      if (hist.size() > PAT_LEN) void'(hist.pop_front());
    end
    #1;
    chk_all(tag);
  endtask

  task automatic feed(input bit b, input string tag);
    a = b;
    tick(tag);
  endtask

  task automatic set_a(input bit b, input string tag);
    a = b;
    #1;
    chk_comb(tag);
  endtask

  task automatic reset_pulse(input string tag);
    ares = 1'b1;
    model_reset();
    #1;
    chk_all(tag);
    ares = 1'b0;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    ares = 1'b1;
    a    = 1'b1;
    #2;
    chk_all("reset_async");

    // held reset with a=1
    for (int i = 0; i < 3; i++) tick("reset_hold");

    // steady a=1 after release: S1 and stays there
    ares = 1'b0;
    feed(1'b1, "steady1");
    feed(1'b1, "steady2");
    chk("steady.state_is_1", 32'(state), 32'd1);

    // basic match then overlap
    feed(1'b0, "to_s2");
    chk("basic.state_is_2", 32'(state), 32'd2);
    set_a(1'b1, "basic.comb_w");
    chk("basic.w_is_1", 32'(w), 32'd1);
    tick("basic.match");
    chk("basic.cnt_is_1", 32'(match_cnt), 32'd1);
    feed(1'b0, "overlap.0");
    feed(1'b1, "overlap.1");
    chk("overlap.cnt_is_2", 32'(match_cnt), 32'd2);

    // mid-cycle input flips in S2
    feed(1'b0, "flip.to_s2");
    set_a(1'b1, "flip.a1");
    set_a(1'b0, "flip.a0");
    set_a(1'b1, "flip.a1b");
    feed(1'b0, "flip.edge0");
    chk("flip.state_is_0", 32'(state), 32'd0);

    // reset mid-sequence discards the partial match
    feed(1'b1, "rst_mid.1");
    feed(1'b0, "rst_mid.0");
    a = 1'b1;
    reset_pulse("rst_mid.pulse");
    feed(1'b0, "rst_mid.after0");
    feed(1'b1, "rst_mid.after1");
    chk("rst_mid.w_q_is_0", 32'(w_q), 32'd0);

    // saturation of the 2-bit counter: 1,2,3,3,3
    reset_pulse("sat.reset");
    a = 1'b1;
    tick("sat.lead");
    for (int m = 0; m < 5; m++) begin
      feed(1'b0, "sat.0");
      feed(1'b1, "sat.1");
    end
    chk("sat.final_is_3", 32'(match_cnt_s), 32'd3);

    // random stream with occasional mid-cycle flips and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse("rand.reset");
      if ($urandom_range(0, 3) == 0) set_a(1'($urandom_range(0, 1)), "rand.flip");
      feed(1'($urandom_range(0, 1)), "rand.edge");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
